// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial scan over voices picks a target for each
// note event, with LRU stealing and a one-cycle gate drop on retrigger.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_BITS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_note_on,
    input  logic [6:0]              ev_note,
    input  logic [6:0]              ev_velocity,
    input  logic [NUM_VOICES-1:0]   voice_idle,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_velocity,
    output logic                    steal,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RETRIG} state_e;

    state_e state_q, state_d;

    logic                  on_q;
    logic [6:0]            note_q;
    logic [6:0]            vel_q;
    logic [VIDX_BITS-1:0]  idx_q;
    logic [VIDX_BITS-1:0]  best_q;
    logic [VIDX_BITS-1:0]  best_rank_q;
    logic [1:0]            best_score_q;
    logic                  found_q;
    logic                  steal_q;
    logic [NUM_VOICES-1:0] gate_q;
    logic [6:0]            vnote_q [NUM_VOICES];
    logic [6:0]            vvel_q  [NUM_VOICES];
    logic [VIDX_BITS-1:0]  rank_q  [NUM_VOICES];

    logic                  cur_gate;
    logic                  cur_match;
    logic [VIDX_BITS-1:0]  cur_rank;
    logic [1:0]            cur_score;
    logic                  take;
    logic                  last_idx;

    assign cur_gate  = gate_q[idx_q];
    assign cur_match = (vnote_q[idx_q] == note_q);
    assign cur_rank  = rank_q[idx_q];
    assign last_idx  = (idx_q == VIDX_BITS'(NUM_VOICES - 1));

    // Higher score = preferred class; score 0 means a steal
    always_comb begin
        cur_score = 2'd0;
        unique case (1'b1)
            cur_gate && cur_match:           cur_score = 2'd3;
            cur_gate && !cur_match:          cur_score = 2'd0;
            !cur_gate && voice_idle[idx_q]:  cur_score = 2'd2;
            !cur_gate && !voice_idle[idx_q]: cur_score = 2'd1;
        endcase
    end

    always_comb begin
        take = 1'b0;
        if (on_q) begin
            take = (idx_q == '0)
                || (cur_score > best_score_q)
                || (cur_score == best_score_q && cur_rank > best_rank_q);
        end else begin
            take = !found_q && cur_gate && cur_match;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ev_valid) state_d = SCAN;
            SCAN:    if (last_idx) state_d = COMMIT;
            COMMIT:  state_d = (found_q && on_q && gate_q[best_q])
                             ? RETRIG : IDLE;
            RETRIG:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ev_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_q         <= 1'b0;
            note_q       <= '0;
            vel_q        <= '0;
            idx_q        <= '0;
            best_q       <= '0;
            best_rank_q  <= '0;
            best_score_q <= '0;
            found_q      <= 1'b0;
            steal_q      <= 1'b0;
            gate_q       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vnote_q[v] <= '0;
                vvel_q[v]  <= '0;
                rank_q[v]  <= VIDX_BITS'(v);
            end
        end else begin
            steal_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ev_valid) begin
                        on_q    <= ev_note_on && (ev_velocity != 7'd0);
                        note_q  <= ev_note;
                        vel_q   <= ev_velocity;
                        idx_q   <= '0;
                        found_q <= 1'b0;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + 1'b1;
                    if (take) begin
                        best_q       <= idx_q;
                        best_rank_q  <= cur_rank;
                        best_score_q <= cur_score;
                        found_q      <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (found_q && on_q) begin
                        vnote_q[best_q] <= note_q;
                        vvel_q[best_q]  <= vel_q;
                        gate_q[best_q]  <= !gate_q[best_q];
                        steal_q         <= (best_score_q == 2'd0);
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (VIDX_BITS'(v) == best_q)
                                rank_q[v] <= '0;
                            else if (rank_q[v] < rank_q[best_q])
                                rank_q[v] <= rank_q[v] + 1'b1;
                        end
                    end else if (found_q) begin
                        gate_q[best_q] <= 1'b0;
                    end
                end
                RETRIG: begin
                    gate_q[best_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        voice_note     = '0;
        voice_velocity = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note[7*v +: 7]     = vnote_q[v];
            voice_velocity[7*v +: 7] = vvel_q[v];
        end
    end

    assign voice_gate = gate_q;
    assign steal      = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator against an LRU-queue reference model.
module tb_voice_allocator;

    localparam int N  = 4;
    localparam int VB = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           ev_valid;
    logic           ev_ready;
    logic           ev_note_on;
    logic [6:0]     ev_note;
    logic [6:0]     ev_velocity;
    logic [N-1:0]   voice_idle;
    logic [N-1:0]   voice_gate;
    logic [7*N-1:0] voice_note;
    logic [7*N-1:0] voice_velocity;
    logic           steal;
    logic           busy;

    int checks = 0;
    int errors = 0;

    bit       mg [N];
    bit [6:0] mn [N];
    bit [6:0] mv [N];
    int       order [$];

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(N), .VIDX_BITS(VB)) dut (
        .clk            (clk),
        .rst            (rst),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_note_on     (ev_note_on),
        .ev_note        (ev_note),
        .ev_velocity    (ev_velocity),
        .voice_idle     (voice_idle),
        .voice_gate     (voice_gate),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .steal          (steal),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        order = {};
        for (int v = 0; v < N; v++) begin
            mg[v] = 1'b0;
            mn[v] = '0;
            mv[v] = '0;
            order.push_back(v);
        end
    endfunction

    function automatic int age(input int v);
        for (int i = 0; i < order.size(); i++)
            if (order[i] == v) return i;
        return -1;
    endfunction

    function automatic logic [63:0] exp_gate();
        logic [63:0] r = '0;
        for (int v = 0; v < N; v++) r[v] = mg[v];
        return r;
    endfunction

    function automatic logic [63:0] exp_note();
        logic [63:0] r = '0;
        for (int v = 0; v < N; v++) r[7*v +: 7] = mn[v];
        return r;
    endfunction

    function automatic logic [63:0] exp_vel();
        logic [63:0] r = '0;
        for (int v = 0; v < N; v++) r[7*v +: 7] = mv[v];
        return r;
    endfunction

    function automatic bit in_class(input int c, input int v,
                                    input bit [6:0] n, input bit [N-1:0] idle);
        case (c)
            1:       return mg[v] && mn[v] == n;
            2:       return !mg[v] && idle[v];
            3:       return !mg[v] && !idle[v];
            default: return mg[v];
        endcase
    endfunction

    task automatic do_event(input bit on, input bit [6:0] n,
                            input bit [6:0] vel, input bit [N-1:0] idle);
        int          ch;
        int          cls;
        int          pick;
        bit          retrig;
        logic [63:0] g;
        logic [63:0] pre_g;
        @(negedge clk);
        chk("ready_before", ev_ready, 1);
        ev_valid    = 1'b1;
        ev_note_on  = on;
        ev_note     = n;
        ev_velocity = vel;
        voice_idle  = idle;
        @(posedge clk);
        @(negedge clk);
        ev_valid    = 1'b0;
        ev_note_on  = 1'($urandom);
        ev_note     = 7'($urandom);
        ev_velocity = 7'($urandom);
        chk("busy_scan", busy, 1);
        chk("ready_scan", ev_ready, 0);
        pre_g = exp_gate();
        repeat (N) @(posedge clk);
        @(negedge clk);
        chk("gate_pre_commit", voice_gate, pre_g);
        ch = -1;
        cls = 0;
        retrig = 1'b0;
        if (on && vel != 0) begin
            for (int c = 1; c <= 4; c++) begin
                if (ch < 0) begin
                    pick = -1;
                    for (int v = 0; v < N; v++)
                        if (in_class(c, v, n, idle) &&
                            (pick < 0 || age(v) > age(pick)))
                            pick = v;
                    if (pick >= 0) begin
                        ch = pick;
                        cls = c;
                    end
                end
            end
            retrig = mg[ch];
            mg[ch] = 1'b1;
            mn[ch] = n;
            mv[ch] = vel;
            order.delete(age(ch));
            order.push_front(ch);
        end else begin
            for (int v = 0; v < N; v++)
                if (ch < 0 && mg[v] && mn[v] == n) ch = v;
            if (ch >= 0) mg[ch] = 1'b0;
        end
        g = exp_gate();
        if (retrig) g[ch] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("gate_commit", voice_gate, g);
        chk("note_commit", voice_note, exp_note());
        chk("vel_commit", voice_velocity, exp_vel());
        chk("steal_commit", steal, cls == 4);
        chk("ready_commit", ev_ready, !retrig);
        if (retrig) begin
            @(posedge clk);
            @(negedge clk);
            chk("gate_retrig", voice_gate, exp_gate());
            chk("steal_retrig", steal, 0);
            chk("ready_retrig", ev_ready, 1);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_gate"}, voice_gate, 0);
        chk({tag, "_note"}, voice_note, 0);
        chk({tag, "_vel"}, voice_velocity, 0);
        chk({tag, "_steal"}, steal, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, ev_ready, 1);
    endtask

    task automatic reset_mid_scan();
        @(negedge clk);
        ev_valid    = 1'b1;
        ev_note_on  = 1'b1;
        ev_note     = 7'd50;
        ev_velocity = 7'd77;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("busy_before_rst", busy, 1);
        rst = 1'b0;
        #1;
        check_reset_state("midscan_rst");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("ready_after_rst", ev_ready, 1);
    endtask

    initial begin
        rst         = 1'b0;
        ev_valid    = 1'b0;
        ev_note_on  = 1'b0;
        ev_note     = '0;
        ev_velocity = '0;
        voice_idle  = '1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;

        do_event(1, 7'd60, 7'd100, 4'hF);
        do_event(1, 7'd62, 7'd90, 4'hF);
        do_event(1, 7'd64, 7'd80, 4'hF);
        do_event(1, 7'd65, 7'd70, 4'hF);
        do_event(1, 7'd67, 7'd50, 4'hF);
        do_event(0, 7'd62, 7'd0, 4'hF);
        do_event(0, 7'd70, 7'd0, 4'hF);
        do_event(0, 7'd64, 7'd0, 4'hF);
        do_event(1, 7'd72, 7'd33, 4'b1011);
        do_event(1, 7'd72, 7'd44, 4'b1011);
        do_event(1, 7'd65, 7'd0, 4'hF);
        do_event(1, 7'd64, 7'd21, 4'b0000);
        do_event(1, 7'd64, 7'd22, 4'b0000);

        for (int i = 0; i < 80; i++) begin
            do_event(1'($urandom),
                     7'(60 + $urandom_range(0, 7)),
                     ($urandom_range(0, 5) == 0) ? 7'd0
                                                 : 7'($urandom_range(1, 127)),
                     N'($urandom));
        end

        reset_mid_scan();
        do_event(1, 7'd61, 7'd99, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
